// File: rtl/mvm_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mvm_pkg : shared definitions for the matrix-vector multiply sequencer.
//   mvm_state_t : controller state encoding
//   N_DEF       : default matrix dimension (N x N matrix, N-element vector)
//   AXW_DEF     : default X memory address width
//   AMW_DEF     : default M memory address / row index width
// ---------------------------------------------------------------------------
package mvm_pkg;

    typedef enum logic [2:0] {
        LOAD_X = 3'd0,  // stream N*N matrix words into X memory
        LOAD_M = 3'd1,  // stream N vector words into M memory
        MAC    = 3'd2,  // issue N reads for one row
        DRAIN  = 3'd3,  // last product lands in the accumulator
        OUT    = 3'd4   // row result presented until accepted
    } mvm_state_t;

    localparam int N_DEF   = 3;
    localparam int AXW_DEF = $clog2(N_DEF * N_DEF);
    localparam int AMW_DEF = $clog2(N_DEF);

endpackage

// File: rtl/mvm_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// mvm_seq_ctrl_if : handshake and datapath control bundle of mvm_seq_ctrl.
//   s_valid/s_ready : input word stream (words carried on the datapath bus)
//   m_valid/m_ready : row result handshake
//   wr_en_x/wr_en_m : X / M memory write enables
//   addr_x/addr_m   : X / M memory addresses (write and read)
//   clr_acc/en_acc  : accumulator clear / accumulate
//   row_idx         : row of the result in progress or presented
// master = the controller, slave = datapath/stream side.
// ---------------------------------------------------------------------------
interface mvm_seq_ctrl_if
    import mvm_pkg::*;
#(
    parameter int AXW = AXW_DEF,
    parameter int AMW = AMW_DEF
);
    logic           s_valid;
    logic           s_ready;
    logic           m_ready;
    logic           m_valid;
    logic           wr_en_x;
    logic           wr_en_m;
    logic [AXW-1:0] addr_x;
    logic [AMW-1:0] addr_m;
    logic           clr_acc;
    logic           en_acc;
    logic [AMW-1:0] row_idx;

    modport master (
        input  s_valid, m_ready,
        output s_ready, m_valid, wr_en_x, wr_en_m, addr_x, addr_m,
               clr_acc, en_acc, row_idx
    );

    modport slave (
        output s_valid, m_ready,
        input  s_ready, m_valid, wr_en_x, wr_en_m, addr_x, addr_m,
               clr_acc, en_acc, row_idx
    );
endinterface

// File: rtl/mvm_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mvm_seq_ctrl : sequencer for an external N x N matrix-vector MAC datapath.
// Loads X (N*N words, row-major) then M (N words) from the input stream,
// then for each row issues N memory reads, lets the datapath accumulate,
// and presents the row result with m_valid until m_ready.
//   clk   : rising-edge clock
//   reset : synchronous, active low
//   bus   : mvm_seq_ctrl_if master (stream, result and datapath control)
// Datapath memories have a 1-cycle synchronous read, so en_acc trails the
// MAC read cycles by one clock; DRAIN covers the last trailing accumulate.
// ---------------------------------------------------------------------------
module mvm_seq_ctrl
    import mvm_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int AXW = $clog2(N * N),
    parameter int AMW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    mvm_seq_ctrl_if.master bus
);

    localparam logic [AXW-1:0] LAST_X = AXW'(N * N - 1);
    localparam logic [AXW-1:0] LAST_M = AXW'(N - 1);
    localparam logic [AMW-1:0] LAST_K = AMW'(N - 1);

    mvm_state_t     state, state_nx;
    logic [AXW-1:0] lc, lc_nx;      // load counter, shared by X and M loads
    logic [AMW-1:0] k, k_nx;        // column counter within a row
    logic [AMW-1:0] row, row_nx;
    logic           en_q;           // (state == MAC) delayed one cycle
    logic           load_st;
    logic           s_hs;
    logic [AXW-1:0] mac_addr_x;

    assign load_st    = (state == LOAD_X) || (state == LOAD_M);
    assign s_hs       = load_st & bus.s_valid;
    assign mac_addr_x = AXW'(row) * AXW'(N) + AXW'(k);

    // -----------------------------------------------------------------------
    // Next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        lc_nx    = lc;
        k_nx     = k;
        row_nx   = row;
        unique case (state)
            LOAD_X: begin
                if (s_hs) begin
                    if (lc == LAST_X) begin
                        lc_nx    = '0;
                        state_nx = LOAD_M;
                    end else begin
                        lc_nx = lc + 1'b1;
                    end
                end
            end
            LOAD_M: begin
                if (s_hs) begin
                    if (lc == LAST_M) begin
                        lc_nx    = '0;
                        row_nx   = '0;
                        state_nx = MAC;
                    end else begin
                        lc_nx = lc + 1'b1;
                    end
                end
            end
            MAC: begin
                if (k == LAST_K) begin
                    k_nx     = '0;
                    state_nx = DRAIN;
                end else begin
                    k_nx = k + 1'b1;
                end
            end
            DRAIN: begin
                state_nx = OUT;
            end
            OUT: begin
                if (bus.m_ready) begin
                    if (row == LAST_K) begin
                        row_nx   = '0;
                        state_nx = LOAD_X;
                    end else begin
                        row_nx   = row + 1'b1;
                        state_nx = MAC;
                    end
                end
            end
            default: begin
                state_nx = LOAD_X;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= LOAD_X;
            lc    <= '0;
            k     <= '0;
            row   <= '0;
            en_q  <= 1'b0;
        end else begin
            state <= state_nx;
            lc    <= lc_nx;
            k     <= k_nx;
            row   <= row_nx;
            en_q  <= (state == MAC);
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: pure decode of state and counters. Every output is forced to
    // zero while reset is low so the datapath sees no activity during reset,
    // even in the cycle before the reset edge takes effect.
    // -----------------------------------------------------------------------
    always_comb begin
        bus.s_ready = 1'b0;
        bus.m_valid = 1'b0;
        bus.wr_en_x = 1'b0;
        bus.wr_en_m = 1'b0;
        bus.addr_x  = '0;
        bus.addr_m  = '0;
        bus.clr_acc = 1'b0;
        bus.en_acc  = 1'b0;
        bus.row_idx = '0;
        if (reset) begin
            bus.row_idx = row;
            bus.en_acc  = en_q;
            unique case (state)
                LOAD_X: begin
                    bus.s_ready = 1'b1;
                    bus.wr_en_x = bus.s_valid;
                    bus.addr_x  = lc;
                end
                LOAD_M: begin
                    bus.s_ready = 1'b1;
                    bus.wr_en_m = bus.s_valid;
                    bus.addr_m  = AMW'(lc);
                end
                MAC: begin
                    bus.addr_x  = mac_addr_x;
                    bus.addr_m  = k;
                    // k = 0 read cycle; the first accumulate comes a cycle later
                    bus.clr_acc = (k == '0);
                end
                OUT: begin
                    bus.m_valid = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mvm_seq_ctrl.sv
module tb_mvm_seq_ctrl;
    import mvm_pkg::*;

    localparam int N   = 3;
    localparam int AXW = $clog2(N * N);
    localparam int AMW = $clog2(N);

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [15:0] s_data = '0;

    always #5 clk = ~clk;

    mvm_seq_ctrl_if #(.AXW(AXW), .AMW(AMW)) bus ();

    mvm_seq_ctrl #(.N(N), .AXW(AXW), .AMW(AMW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Behavioural datapath: sync-read memories and accumulator.
    logic [15:0] xmem [0:N*N-1];
    logic [15:0] mmem [0:N-1];
    logic [15:0] xr, mr, acc;

    always @(posedge clk) begin
        if (bus.wr_en_x) xmem[bus.addr_x] <= s_data;
        if (bus.wr_en_m) mmem[bus.addr_m] <= s_data;
        xr <= xmem[bus.addr_x];
        mr <= mmem[bus.addr_m];
        if (bus.clr_acc)     acc <= '0;
        else if (bus.en_acc) acc <= acc + xr * mr;
    end

    typedef struct packed {
        logic           s_ready;
        logic           m_valid;
        logic           wr_en_x;
        logic           wr_en_m;
        logic [AXW-1:0] addr_x;
        logic [AMW-1:0] addr_m;
        logic           clr_acc;
        logic           en_acc;
        logic [AMW-1:0] row_idx;
    } outs_t;

    typedef struct {
        logic        sv;
        logic        mrdy;
        logic [15:0] data;
        outs_t       exp;
    } vec_t;

    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic outs_t get_outs();
        outs_t o;
        o.s_ready = bus.s_ready;
        o.m_valid = bus.m_valid;
        o.wr_en_x = bus.wr_en_x;
        o.wr_en_m = bus.wr_en_m;
        o.addr_x  = bus.addr_x;
        o.addr_m  = bus.addr_m;
        o.clr_acc = bus.clr_acc;
        o.en_acc  = bus.en_acc;
        o.row_idx = bus.row_idx;
        return o;
    endfunction

    function automatic outs_t mko(input int sr, mv, wx, wm, ax, am, clr, en, row);
        outs_t o;
        o.s_ready = 1'(sr);
        o.m_valid = 1'(mv);
        o.wr_en_x = 1'(wx);
        o.wr_en_m = 1'(wm);
        o.addr_x  = AXW'(ax);
        o.addr_m  = AMW'(am);
        o.clr_acc = 1'(clr);
        o.en_acc  = 1'(en);
        o.row_idx = AMW'(row);
        return o;
    endfunction

    function automatic vec_t mk(input int sv, mrdy, d, sr, mv, wx, wm, ax, am, clr, en, row);
        vec_t v;
        v.sv   = 1'(sv);
        v.mrdy = 1'(mrdy);
        v.data = 16'(d);
        v.exp  = mko(sr, mv, wx, wm, ax, am, clr, en, row);
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the caller at a negedge where m_valid was sampled high.
    task automatic wait_mv(input int bound);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.m_valid && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("mv_timeout", 64'(bus.m_valid), 64'(1));
    endtask

    int xw [0:N*N-1];
    int mw [0:N-1];

    initial begin
        int writes, cnt, exp_row, got, prev_row, sum;
        logic prev_hold;
        outs_t zero;
        zero = '0;

        // ---- table: one full frame, X = 1..9, M = {1,1,1}, s_valid left high
        for (int i = 0; i < 9; i++) tbl.push_back(mk(1, 1, i + 1, 1, 0, 1, 0, i, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 1, 1,     1, 0, 0, 1, 0, i, 0, 0, 0));
        for (int r = 0; r < 3; r++) begin
            tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 3*r,     0, 1, 0, r));
            tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 3*r + 1, 1, 0, 1, r));
            tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 3*r + 2, 2, 0, 1, r));
            tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0,       0, 0, 1, r));
            tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0,       0, 0, 0, r));
        end
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));

        // ---- reset state
        bus.s_valid = 1'b1;
        bus.m_ready = 1'b1;
        @(negedge clk);
        chk("reset_pre_edge", 64'(get_outs()), 64'(zero));
        @(negedge clk);
        chk("reset_held", 64'(get_outs()), 64'(zero));
        @(posedge clk);
        #1;
        reset = 1'b1;

        // ---- table-driven frame
        foreach (tbl[i]) begin
            bus.s_valid = tbl[i].sv;
            bus.m_ready = tbl[i].mrdy;
            s_data      = tbl[i].data;
            @(negedge clk);
            chk($sformatf("vec%0d", i), 64'(get_outs()), 64'(tbl[i].exp));
            if (tbl[i].exp.m_valid)
                chk($sformatf("result_row%0d", tbl[i].exp.row_idx), 64'(acc),
                    64'(6 + 9 * int'(tbl[i].exp.row_idx)));
            tick();
        end

        // ---- second frame, M = {2,0,1}: stall in OUT at row 1
        bus.m_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bus.s_valid = 1'b1;
            s_data = (i < 9) ? 16'(i + 1) : ((i == 9) ? 16'd2 : ((i == 10) ? 16'd0 : 16'd1));
            tick();
        end
        bus.s_valid = 1'b0;
        wait_mv(20);
        chk("f2_row0", 64'({bus.row_idx, acc}), 64'({AMW'(0), 16'd5}));
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        wait_mv(20);
        chk("f2_row1", 64'({bus.row_idx, acc}), 64'({AMW'(1), 16'd14}));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("stall%0d", c), 64'(get_outs()), 64'(mko(0, 1, 0, 0, 0, 0, 0, 0, 1)));
        end
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;

        // ---- reset pulse in MAC of row 2
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_outs", 64'(get_outs()), 64'(zero));
        tick();
        reset = 1'b1;
        bus.s_valid = 1'b1;
        s_data = 16'd7;
        @(negedge clk);
        chk("rst_first_wr", 64'(get_outs()), 64'(mko(1, 0, 1, 0, 0, 0, 0, 0, 0)));
        tick();

        // ---- s_valid toggling during X load: writes only on handshakes
        writes = 1;
        for (int j = 0; j < 16; j++) begin
            bus.s_valid = 1'(j % 2);
            @(negedge clk);
            chk($sformatf("toggle%0d", j), 64'(get_outs()),
                64'(mko(1, 0, j % 2, 0, writes, 0, 0, 0, 0)));
            tick();
            if (j % 2 == 1) writes++;
        end
        bus.s_valid = 1'b0;
        @(negedge clk);
        chk("toggle_to_load_m", 64'(get_outs()), 64'(mko(1, 0, 0, 0, 0, 0, 0, 0, 0)));

        // ---- random stream with scoreboard and per-cycle property checks
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        cnt = 0; exp_row = 0; got = 0; prev_hold = 1'b0; prev_row = 0;
        for (int c = 0; c < 600; c++) begin
            bus.s_valid = 1'($urandom_range(0, 1));
            bus.m_ready = 1'($urandom_range(0, 1));
            s_data      = 16'($urandom_range(0, 15));
            @(negedge clk);
            chk("excl", 64'($onehot0({bus.wr_en_x, bus.wr_en_m, bus.clr_acc, bus.en_acc})), 64'(1));
            if (prev_hold)
                chk("hold", 64'({bus.m_valid, bus.row_idx}), 64'({1'b1, AMW'(prev_row)}));
            if (bus.s_ready && bus.s_valid) begin
                if (cnt < N * N) xw[cnt] = int'(s_data);
                else             mw[cnt - N * N] = int'(s_data);
                cnt = (cnt == N * N + N - 1) ? 0 : cnt + 1;
            end
            if (bus.m_valid && bus.m_ready) begin
                sum = 0;
                for (int j = 0; j < N; j++) sum += xw[exp_row * N + j] * mw[j];
                chk("rand_result", 64'({bus.row_idx, acc}), 64'({AMW'(exp_row), 16'(sum)}));
                exp_row = (exp_row == N - 1) ? 0 : exp_row + 1;
                got++;
            end
            prev_hold = bus.m_valid & ~bus.m_ready;
            prev_row  = int'(bus.row_idx);
            tick();
        end
        chk("rand_progress", 64'(got > 3), 64'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mvm_seq_ctrl.md
MVM_SEQ_CTRL -- requirements
Module: mvm_seq_ctrl

Interface
Parameters:
REQ-001 The block SHALL have parameter N, default 3, giving the matrix dimension (N x N matrix X, N-element vector M).
REQ-002 The block SHALL have parameter AXW, default $clog2(N*N), giving the width of addr_x.
REQ-003 The block SHALL have parameter AMW, default $clog2(N), giving the width of addr_m and row_idx.

Ports:
REQ-004 The block SHALL have these ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low; 0 = reset.
- s_valid  in  1  input stream word valid.
- s_ready  out  1  controller accepts an input word.
- m_ready  in  1  downstream accepts the current result.
- m_valid  out  1  result of row row_idx is held on the datapath accumulator.
- wr_en_x  out  1  write enable of the X memory.
- wr_en_m  out  1  write enable of the M memory.
- addr_x  out  AXW  X memory address, for write and read.
- addr_m  out  AMW  M memory address, for write and read.
- clr_acc  out  1  clear the datapath accumulator.
- en_acc  out  1  accumulate the current X*M product.
- row_idx  out  AMW  row index of the result in progress or presented.

Function
REQ-005 States SHALL be LOAD_X, LOAD_M, MAC, DRAIN and OUT, encoded as an enum.
REQ-006 s_ready SHALL be 1 only in LOAD_X and LOAD_M, decoded combinationally from state.
REQ-007 In LOAD_X: wr_en_x = s_valid & s_ready; addr_x = load counter lc.
- lc SHALL increment on each handshake.
- On the handshake with lc = N*N-1, lc SHALL become 0 and the state SHALL become LOAD_M.
REQ-008 In LOAD_M: wr_en_m = s_valid & s_ready; addr_m = lc.
- On the handshake with lc = N-1, lc SHALL become 0, row_idx SHALL become 0 and the state SHALL become MAC.
REQ-009 When s_valid = 0 in a load state, the block SHALL assert no write enable and SHALL hold lc unchanged.
REQ-010 In MAC: column counter k SHALL run from 0 to N-1, one step per cycle.
- addr_x = row_idx*N + k; addr_m = k; no write enables.
- At k = N-1 the next state SHALL be DRAIN.
REQ-011 clr_acc SHALL be 1 exactly in the MAC cycle with k = 0.
REQ-012 en_acc SHALL be the one-cycle registered copy of (state == MAC), matching the datapath's 1-cycle synchronous memory read.
REQ-013 DRAIN SHALL last exactly one cycle (the last en_acc) and then go to OUT.
REQ-014 In OUT: m_valid = 1 with row_idx stable, and addresses, clr_acc and en_acc held at 0 until m_valid & m_ready.
REQ-015 On m_valid & m_ready with row_idx < N-1, row_idx SHALL increment and the state SHALL become MAC.
REQ-016 On m_valid & m_ready with row_idx = N-1, row_idx SHALL become 0 and the state SHALL become LOAD_X.
REQ-017 Latency SHALL be:
- last LOAD_M handshake in cycle t -> m_valid in cycle t+N+2;
- OUT handshake in cycle t -> next m_valid in cycle t+N+2.
REQ-018 m_valid SHALL never drop without m_ready, and row_idx SHALL never change while m_valid = 1.
REQ-019 m_ready SHALL be ignored outside OUT, and s_valid SHALL be ignored outside the load states.
REQ-020 wr_en_x, wr_en_m, clr_acc and en_acc SHALL be mutually exclusive in every cycle.
REQ-021 addr_x and addr_m SHALL be 0 in states where they are not used.

Reset
REQ-022 While reset = 0 at a clock edge, the block SHALL set: state = LOAD_X, lc = 0, k = 0, row_idx = 0, en_acc register = 0.
REQ-023 During reset, all outputs SHALL be 0 except s_ready, which follows REQ-006 (1 in LOAD_X) only after reset is released.
REQ-024 Reset asserted mid-operation (any state) SHALL discard all progress: the next frame starts at X address 0.

Structure
REQ-025 A shared package mvm_pkg SHALL hold the state enum type mvm_state_t and the default N, AXW and AMW constants.
REQ-026 The block SHALL be a single module with no sub-modules.
REQ-027 The block SHALL instantiate no datapath; the integrating top SHALL connect it to the existing MAC datapath.

Verification
REQ-028 Continuous s_valid, 12 words, m_ready = 1 -> wr_en_x on addr_x 0..8, then wr_en_m on addr_m 0..2, first m_valid exactly 5 cycles after the 12th handshake.
REQ-029 With the datapath attached, X = 1..9 row-major and M = {1,1,1} -> results 6, 15, 24 with row_idx 0, 1, 2, then s_ready = 1.
REQ-030 m_ready = 0 for 10 cycles in OUT at row 1 -> m_valid, row_idx = 1 and all addresses held; no en_acc or clr_acc.
REQ-031 s_valid toggling 1,0,1,0 during load -> writes only on handshake cycles, addresses contiguous with no gaps or duplicates.
REQ-032 reset = 0 for 1 cycle during MAC of row 2 -> all outputs 0; after release s_ready = 1 and the next write goes to addr_x 0.
REQ-033 Assertions over a random stream: REQ-018 and REQ-020 hold in every cycle.
